aes_subbytes_pipe: RTL and testbench

//  Pipelined, multi-lane AES SubBytes / InvSubBytes engine with valid/ready handshake.

---
 rtl/aes_pkg.sv | 39 +++
 rtl/aes_gf_inv.sv | 27 ++
 rtl/aes_subbytes_pipe.sv | 110 +++++++++++
 tb/tb_aes_subbytes_pipe.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES byte-level types, constants and GF(2^8) helpers.
// Used by the SubBytes engine and its GF inverse sub-module.
package aes_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t      AES_SBOX_C = 8'h63;
  localparam logic [8:0] AES_POLY   = 9'h11B;

  function automatic byte_t gf_mul(byte_t a, byte_t b);
    byte_t p;
    byte_t t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? AES_POLY[7:0] : 8'h00);
    end
    return p;
  endfunction

  function automatic byte_t gf_sq(byte_t a);
    return gf_mul(a, a);
  endfunction

  function automatic byte_t affine_fwd(byte_t x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]}
             ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]}
             ^ AES_SBOX_C;
  endfunction

  function automatic byte_t affine_inv(byte_t x);
    byte_t z;
    z = x ^ AES_SBOX_C;
    return {z[6:0], z[7]} ^ {z[4:0], z[7:5]}
         ^ {z[1:0], z[7:2]};
  endfunction

endpackage

// File: rtl/aes_gf_inv.sv
// Combinational GF(2^8) multiplicative inverse, 0 maps to 0.
// Evaluated as x^254 with a short square-and-multiply chain.
module aes_gf_inv
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  byte_t x2, x3, x6, x12, x14, x15;
  byte_t x30, x60, x120, x240;

  always_comb begin
    x2   = gf_sq(a);
    x3   = gf_mul(x2, a);
    x6   = gf_sq(x3);
    x12  = gf_sq(x6);
    x14  = gf_mul(x12, x2);
    x15  = gf_mul(x12, x3);
    x30  = gf_sq(x15);
    x60  = gf_sq(x30);
    x120 = gf_sq(x60);
    x240 = gf_sq(x120);
    y    = gf_mul(x240, x14);
  end

endmodule

// File: rtl/aes_subbytes_pipe.sv
// Pipelined multi-lane AES SubBytes / InvSubBytes engine.
// One algebraic datapath serves both directions via a per-beat tag.
module aes_subbytes_pipe
  import aes_pkg::*;
#(
  parameter int LANES = 16,
  parameter int PIPE  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [8*LANES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_inv,
  output logic [8*LANES-1:0] out_data
);

  localparam int W = 8 * LANES;

  logic [W-1:0] map_d;
  logic [W-1:0] s2_d;
  logic [W-1:0] s2_g;
  logic [W-1:0] s2_y;
  logic         s2_v;
  logic         s2_inv;
  logic         rdy2;

  always_comb begin
    map_d = '0;
    for (int i = 0; i < LANES; i++) begin
      map_d[8*i +: 8] = in_inv ? affine_inv(in_data[8*i +: 8])
                               : in_data[8*i +: 8];
    end
  end

  assign rdy2 = !out_valid | out_ready;

  generate
    if (PIPE == 2) begin : g_p2
      logic         v1;
      logic         i1;
      logic [W-1:0] d1;
      logic         rdy1;

      assign rdy1     = !v1 | rdy2;
      assign in_ready = rst_n & ~flush & rdy1;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v1 <= 1'b0;
          i1 <= 1'b0;
          d1 <= '0;
        end else if (flush) begin
          v1 <= 1'b0;
        end else if (rdy1) begin
          v1 <= in_valid;
          if (in_valid) begin
            i1 <= in_inv;
            d1 <= map_d;
          end
        end
      end

      assign s2_v   = v1;
      assign s2_inv = i1;
      assign s2_d   = d1;
    end else begin : g_p1
      assign in_ready = rst_n & ~flush & rdy2;
      assign s2_v     = in_valid;
      assign s2_inv   = in_inv;
      assign s2_d     = map_d;
    end
  endgenerate

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_gf_inv u_inv (
      .a (s2_d[8*l +: 8]),
      .y (s2_g[8*l +: 8])
    );
  end

  always_comb begin
    s2_y = '0;
    for (int i = 0; i < LANES; i++) begin
      s2_y[8*i +: 8] = s2_inv ? s2_g[8*i +: 8]
                              : affine_fwd(s2_g[8*i +: 8]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_inv   <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (rdy2) begin
      out_valid <= s2_v;
      if (s2_v) begin
        out_inv  <= s2_inv;
        out_data <= s2_y;
      end
    end
  end

endmodule

// File: tb/tb_aes_subbytes_pipe.sv
// Self-checking bench for aes_subbytes_pipe (4 lanes, 2 stages).
// Reference S-box tables are built from first principles at time zero.
module tb_aes_subbytes_pipe;

  localparam int LANES = 4;
  localparam int PIPE  = 2;
  localparam int W     = 8 * LANES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_inv = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_inv;
  logic [W-1:0] out_data;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [W:0]   q [$];

  aes_subbytes_pipe #(.LANES(LANES), .PIPE(PIPE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inv    (in_inv),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inv   (out_inv),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // carry-less multiply then long-division by x^8+x^4+x^3+x+1
  function automatic logic [7:0] pmul(logic [7:0] a, logic [7:0] b);
    logic [14:0] p;
    logic [14:0] ae;
    logic [14:0] m;
    p  = '0;
    ae = {7'b0, a};
    m  = 15'h11B;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (ae << i);
    for (int k = 14; k >= 8; k--)
      if (p[k]) p = p ^ (m << (k - 8));
    return p[7:0];
  endfunction

  function automatic void build_tables();
    logic [7:0] v;
    logic [7:0] b;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      v = 8'h00;
      for (int y = 1; y < 256; y++)
        if (pmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      for (int i = 0; i < 8; i++)
        b[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8]
             ^ v[(i+6)%8] ^ v[(i+7)%8] ^ c[i];
      sbox[x]  = b;
      isbox[b] = 8'(x);
    end
  endfunction

  function automatic logic [W:0] model(logic inv, logic [W-1:0] d);
    logic [W-1:0] r;
    for (int l = 0; l < LANES; l++)
      r[8*l +: 8] = inv ? isbox[d[8*l +: 8]] : sbox[d[8*l +: 8]];
    return {inv, r};
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  // mode 1: expect full-rate flow, mode 2: expect stalled input
  task automatic step(int mode);
    logic [W:0] e;
    @(negedge clk);
    if (mode == 1) begin
      chk("tp_in_ready", 64'(in_ready), 64'd1);
      chk("tp_out_valid", 64'(out_valid), 64'd1);
    end
    if (mode == 2) chk("bp_in_ready", 64'(in_ready), 64'd0);
    if (out_valid && out_ready) begin
      chk("extra_beat", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("beat", 64'({out_inv, out_data}), 64'(e));
      end
    end
    if (in_valid && in_ready) q.push_back(model(in_inv, in_data));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) step(0);
  endtask

  initial begin
    build_tables();

    #2 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_inv", 64'(out_inv), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // fixed-latency directed vectors
    for (int t = 0; t < 2; t++) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_inv    = t[0];
      in_data   = (t == 0) ? 32'h01ff5300 : 32'h0016ed63;
      @(negedge clk);
      chk("dir_accept", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int c = 1; c < PIPE; c++) begin
        @(negedge clk);
        chk("dir_early", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      chk("dir_valid", 64'(out_valid), 64'd1);
      chk("dir_inv", 64'(out_inv), 64'(t));
      chk("dir_data", 64'(out_data),
          (t == 0) ? 64'h7c16ed63 : 64'h52ff5300);
      @(posedge clk);
      #1;
    end
    drain(3);

    // every byte value, both directions
    for (int t = 0; t < 2; t++)
      for (int k = 0; k < 64; k++) begin
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_inv    = t[0];
        for (int l = 0; l < LANES; l++)
          in_data[8*l +: 8] = 8'(4*k + l);
        step(0);
      end
    drain(4);

    // round trip: feed forward results back in inverse mode
    for (int k = 0; k < 64; k++) begin
      in_valid = 1'b1;
      in_inv   = 1'b1;
      for (int l = 0; l < LANES; l++)
        in_data[8*l +: 8] = sbox[4*k + l];
      step(0);
    end
    drain(4);

    // alternating modes at full rate
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 42; k++) begin
      in_inv  = k[0];
      in_data = $urandom;
      step((k >= PIPE) ? 1 : 0);
    end
    drain(4);

    // backpressure: fill, hold, release
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      in_inv  = 1'($urandom);
      in_data = $urandom;
      step((k >= PIPE) ? 2 : 0);
    end
    out_ready = 1'b1;
    step(1);
    drain(5);

    // flush with stages full
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_data = $urandom;
      step(0);
    end
    flush = 1'b1;
    step(2);
    flush    = 1'b0;
    in_valid = 1'b0;
    q.delete();
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    drain(6);

    // reset mid-operation
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_data = $urandom;
      step(0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    drain(6);

    // random traffic with random backpressure
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom % 5) != 0;
      in_inv    = 1'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom % 4) != 0;
      step(0);
    end
    drain(8);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
